// File: rtl/fnd_pkg.sv
// Shared constants and types for the FND scan display path.
package fnd_pkg;
    localparam int FND_DIGITS = 4;
    localparam int BCD_W      = 4;
    localparam int BIN_W      = 14;
    localparam int MAX_VALUE  = 9999;
    localparam int DISP_W     = FND_DIGITS * BCD_W;
    localparam int ITER_W     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    // Values above 9999 cannot be shown on four digits, so they saturate.
    function automatic logic [BIN_W-1:0] clamp_value(input logic [BIN_W-1:0] v);
        return (v > BIN_W'(MAX_VALUE)) ? BIN_W'(MAX_VALUE) : v;
    endfunction
endpackage

// File: rtl/fnd_scan_controller_if.sv
// Application-side bundle of the FND scan controller.
interface fnd_scan_controller_if;
    import fnd_pkg::*;

    // i_load is a one-cycle strobe taken only while o_busy is low; strobes seen
    // while o_busy is high are dropped, never queued.
    logic [BIN_W-1:0] i_value;
    logic             i_load;
    logic             i_en;
    logic             i_blank_lz;
    logic [1:0]       o_digit_sel;
    logic [BCD_W-1:0] o_value;
    logic             o_fnd_en;
    logic             o_busy;
    logic             o_ovf;
    conv_state_t      conv_state;

    modport master (
        output i_value, i_load, i_en, i_blank_lz,
        input  o_digit_sel, o_value, o_fnd_en, o_busy, o_ovf, conv_state
    );

    modport slave (
        input  i_value, i_load, i_en, i_blank_lz,
        output o_digit_sel, o_value, o_fnd_en, o_busy, o_ovf, conv_state
    );
endinterface

// File: rtl/fnd_scan_controller_conv.sv
// bin2bcd_seq: sequential double-dabble, one bit per cycle, 14 iterations.
module bin2bcd_seq
    import fnd_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [BIN_W-1:0]  bin_in,
    output logic              busy,
    output logic              done,
    output logic [DISP_W-1:0] bcd,
    output conv_state_t       state
);
    conv_state_t       state_q, state_d;
    logic [BIN_W-1:0]  bin_q, bin_d;
    logic [DISP_W-1:0] bcd_q, bcd_d, adj;
    logic [ITER_W-1:0] iter_q, iter_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            iter_q  <= iter_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        iter_d  = iter_q;
        adj     = bcd_q;
        for (int k = 0; k < FND_DIGITS; k++) begin
            if (bcd_q[k*BCD_W +: BCD_W] >= 4'd5)
                adj[k*BCD_W +: BCD_W] = bcd_q[k*BCD_W +: BCD_W] + 4'd3;
        end
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d   = bin_in;
                    bcd_d   = '0;
                    iter_d  = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_d, bin_d} = {adj, bin_q} << 1;
                iter_d = iter_q + 1'b1;
                if (iter_q == ITER_W'(BIN_W - 1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);
    assign bcd   = bcd_q;
    assign state = state_q;
endmodule

// File: rtl/fnd_scan_controller.sv
// Top: display register, refresh divider, digit mux and leading-zero blanking.
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int SCAN_DIV = 100_000
) (
    input logic                  i_clk,
    input logic                  i_reset,
    fnd_scan_controller_if.slave bus
);
    localparam int CNT_W = $clog2(SCAN_DIV);

    logic                  busy, done, load_ok, upper_zero, ovf_q;
    logic [BIN_W-1:0]      clamped;
    logic [DISP_W-1:0]     result, disp_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [1:0]            sel_q;
    logic [FND_DIGITS-1:0] blank;
    conv_state_t           conv_state;

    assign clamped = clamp_value(bus.i_value);
    assign load_ok = bus.i_load & ~busy;

    bin2bcd_seq u_conv (
        .clk    (i_clk),
        .reset  (i_reset),
        .start  (bus.i_load),
        .bin_in (clamped),
        .busy   (busy),
        .done   (done),
        .bcd    (result),
        .state  (conv_state)
    );

    // The display only ever changes on DONE, so a reset mid-conversion leaves 0000.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            disp_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (done)    disp_q <= result;
            if (load_ok) ovf_q  <= (bus.i_value > BIN_W'(MAX_VALUE));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
            sel_q <= '0;
        end else if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            cnt_q <= '0;
            sel_q <= sel_q + 1'b1;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // A digit is blank only if it and every more significant digit are zero.
    always_comb begin
        blank      = '0;
        upper_zero = 1'b1;
        for (int k = FND_DIGITS - 1; k > 0; k--) begin
            upper_zero = upper_zero & (disp_q[k*BCD_W +: BCD_W] == 4'd0);
            blank[k]   = bus.i_blank_lz & upper_zero;
        end
    end

    assign bus.o_digit_sel = sel_q;
    assign bus.o_value     = disp_q[{sel_q, 2'b00} +: BCD_W];
    assign bus.o_fnd_en    = bus.i_en & ~blank[sel_q] & ~i_reset;
    assign bus.o_busy      = busy;
    assign bus.o_ovf       = ovf_q;
    assign bus.conv_state  = conv_state;
endmodule

// File: doc/fnd_scan_controller.md
# fnd_scan_controller

Sequencer for the 4-digit 7-segment (FND) display path. It accepts a 14-bit binary value and converts it to four BCD digits with a sequential double-dabble engine. It then time-multiplexes those digits onto the downstream digit-select and BCD-to-font decoders using a programmable refresh divider, with optional leading-zero blanking. It sits between application logic and the existing combinational FND decoders.

## Interface
- SCAN_DIV, 100_000, clock cycles each digit is held (≥2); 1 ms per digit at 100 MHz
- i_clk  in  1  system clock, all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_value  in  14  binary value to display (0–9999 valid)
- i_load  in  1  single-cycle strobe: capture i_value and start conversion
- i_en  in  1  display enable, gates o_fnd_en
- i_blank_lz  in  1  1 = blank leading zero digits
- o_digit_sel  out  2  active digit index to select decoder (0 = units … 3 = thousands)
- o_value  out  4  BCD digit for font decoder
- o_fnd_en  out  1  enable for both decoders for current digit
- o_busy  out  1  conversion in progress; i_load ignored
- o_ovf  out  1  last accepted value exceeded 9999 (clamped)

## Operation
- Conversion FSM: IDLE, SHIFT, DONE.
  - IDLE: on i_load=1, capture min(i_value, 9999) into shift register, clear BCD accumulator, iter=0.
    - Same edge: o_ovf <= (i_value > 9999). Go to SHIFT.
  - SHIFT: per cycle, add 3 to every BCD nibble ≥5, then shift {bcd, bin} left 1. iter++. After iteration 14 (iter==13 at the edge), go to DONE.
  - DONE: copy the 4 BCD nibbles into the display register. Go to IDLE.
- i_load while o_busy=1: ignored, no queueing; display and o_ovf unchanged.
- Display register holds the last completed conversion. Scanning never stalls during conversion; it shows the old digits until DONE.
- Scan: counter 0..SCAN_DIV-1. On wrap, o_digit_sel increments 0→1→2→3→0.
- o_value = display nibble[o_digit_sel] (combinational from registers).
- Leading-zero blank: digit k is blank when i_blank_lz=1, k≠0, and all nibbles k..3 are zero. Digit 0 is never blanked.
- o_fnd_en = i_en & ~blank(o_digit_sel) & ~i_reset.
- Arithmetic: clamp applied before conversion, so BCD nibbles are always 0–9. Scan counter width is clog2(SCAN_DIV).

## Timing
- Reset (i_reset=1 at an edge): state IDLE, display 0000, scan counter 0, o_digit_sel 0, o_busy 0, o_ovf 0.
  - o_value = 0 after reset.
  - o_fnd_en = 0 while i_reset is high.
- Reset mid-conversion: conversion aborted, display cleared to 0000, no partial update.
- Load accepted at edge N: o_busy=1 from after N through edge N+15.
  - Display updated at edge N+15; o_busy=0 after N+15.
  - Earliest next accepted load is edge N+16.
- Conversion latency is 15 cycles, from the i_load edge to the display update.
- o_digit_sel changes exactly every SCAN_DIV cycles. First change occurs at edge SCAN_DIV after reset release.
- Display update and digit-select wrap on the same edge: o_value reflects the new display and new index from the next cycle. No glitch cycle with mixed data.
- i_en, i_blank_lz: no latency, combinational to o_fnd_en.

## Structure
- Shared package fnd_pkg:
  - FND_DIGITS = 4, BCD_W = 4, BIN_W = 14, MAX_VALUE = 9999
  - Enum conv_state_t {IDLE, SHIFT, DONE}
- Sub-module bin2bcd_seq: the conversion FSM and shift engine, with start/busy/done and a 16-bit BCD result.
- Top level owns the display register, scan divider, digit mux and blanking.

## Test plan
- Reset, SCAN_DIV=4, i_en=1, i_blank_lz=0 → o_digit_sel cycles 0,1,2,3,0 every 4 clocks; o_value=0; o_fnd_en=1.
- i_load with i_value=1234 → o_busy high exactly 15 cycles; afterwards the scan shows digits 4,3,2,1 at sel 0..3; o_ovf=0.
- i_load with i_value=12000 → display 9999, o_ovf=1. A subsequent load of 5 clears o_ovf; display 0005.
- i_value=7, i_blank_lz=1 → o_fnd_en=1 only at sel 0 (o_value=7). Value 0 → only units lit, showing 0. Value 1005 → all four enabled.
- Second i_load (value 42) issued 5 cycles after a load of 1234 → ignored; final display 1234. Load of 42 after o_busy falls → display 0042.
- i_reset asserted at iteration 7 of the 9876 conversion → next cycle o_busy=0, display 0000, o_digit_sel=0; o_fnd_en=0 during reset.
